// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS HI/LO multiply/divide unit.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
// Signed operations run on magnitudes, and the unit applies the sign when it writes the result.
// Optional macro MULTDIV_DIVIDE_EN compiles in the divide datapath.
// Without it, DIV/DIVU requests are ignored.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CountW = $clog2(WIDTH) + 1;
    localparam logic [CountW-1:0] LastCount = CountW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} stateType;
    stateType state, nextState;

    logic [CountW-1:0]  count;
    logic [WIDTH-1:0]   hiWork;
    logic [WIDTH-1:0]   loWork;
    logic [WIDTH-1:0]   magB;
    logic               negA;
    logic               negB;
    logic               opAllowed;
    logic               accept;
    logic               iterDone;
    logic               signedOp;
    logic [WIDTH-1:0]   magAIn;
    logic [WIDTH-1:0]   magBIn;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] product;

`ifdef MULTDIV_DIVIDE_EN
    logic             isDiv;
    logic [WIDTH:0]   divShift;
    logic             divFits;
    logic [WIDTH-1:0] divDiff;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    assign opAllowed = 1'b1;
`else
    assign opAllowed = ~op[1];
`endif

    // Operand conditioning, handshake decode and status outputs.
    always_comb begin
        signedOp = ~op[0];
        magAIn   = (signedOp && operandA[WIDTH-1]) ? -operandA : operandA;
        magBIn   = (signedOp && operandB[WIDTH-1]) ? -operandB : operandB;
        accept   = start && opAllowed && ((state == IDLE) || (state == FINISH));
        iterDone = (count == LastCount);
        busy     = (state == RUN);
        done     = (state == FINISH);
    end

    // One step of each datapath, plus the sign-corrected final results.
    always_comb begin
        mulSum  = {1'b0, hiWork} + (loWork[0] ? {1'b0, magB} : {(WIDTH+1){1'b0}});
        product = (negA ^ negB) ? -{hiWork, loWork} : {hiWork, loWork};
`ifdef MULTDIV_DIVIDE_EN
        // The remainder always fits in WIDTH bits.
        // So the low WIDTH bits of the difference are exact whenever the divisor fits.
        divShift  = {hiWork, loWork[WIDTH-1]};
        divFits   = (divShift >= {1'b0, magB});
        divDiff   = divShift[WIDTH-1:0] - magB;
        remainder = negA ? -hiWork : hiWork;
        if (magB == '0) begin
            quotient = '1;
        end else begin
            quotient = (negA ^ negB) ? -loWork : loWork;
        end
`endif
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: a new request may be taken in IDLE or in the done cycle.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = RUN;
            RUN:     if (iterDone) nextState = FINISH;
            FINISH:  nextState = accept ? RUN : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate during RUN, publish HI/LO once at the end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= '0;
            hiWork <= '0;
            loWork <= '0;
            magB   <= '0;
            negA   <= 1'b0;
            negB   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULTDIV_DIVIDE_EN
            isDiv  <= 1'b0;
`endif
        end else if (accept) begin
            count  <= '0;
            hiWork <= '0;
            loWork <= magAIn;
            magB   <= magBIn;
            negA   <= signedOp & operandA[WIDTH-1];
            negB   <= signedOp & operandB[WIDTH-1];
`ifdef MULTDIV_DIVIDE_EN
            isDiv  <= op[1];
`endif
        end else if (state == RUN) begin
            if (!iterDone) begin
                count <= count + 1'b1;
`ifdef MULTDIV_DIVIDE_EN
                if (isDiv) begin
                    if (divFits) begin
                        hiWork <= divDiff;
                        loWork <= {loWork[WIDTH-2:0], 1'b1};
                    end else begin
                        hiWork <= divShift[WIDTH-1:0];
                        loWork <= {loWork[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hiWork <= mulSum[WIDTH:1];
                    loWork <= {mulSum[0], loWork[WIDTH-1:1]};
                end
`else
                hiWork <= mulSum[WIDTH:1];
                loWork <= {mulSum[0], loWork[WIDTH-1:1]};
`endif
            end else begin
`ifdef MULTDIV_DIVIDE_EN
                if (isDiv) begin
                    hi <= remainder;
                    lo <= quotient;
                end else begin
                    {hi, lo} <= product;
                end
`else
                {hi, lo} <= product;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit.
// It compares the DUT against a plain-arithmetic HI/LO model.
// Divide tests follow MULTDIV_DIVIDE_EN, the same macro the RTL uses.
module tb_mult_div_unit;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference HI/LO results computed directly from the MIPS arithmetic rules.
    function automatic void refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rh, output logic [31:0] rl);
        longint      sa, sb, q, r;
        logic [63:0] u;
        case (o)
            OpMult: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                u  = 64'(sa * sb);
                {rh, rl} = u;
            end
            OpMultu: begin
                u = {32'b0, a} * {32'b0, b};
                {rh, rl} = u;
            end
            default: begin
                if (b == 32'd0) begin
                    rh = a;
                    rl = 32'hFFFFFFFF;
                end else begin
                    if (o == OpDiv) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'b0, a});
                        sb = longint'({32'b0, b});
                    end
                    q  = sa / sb;
                    r  = sa % sb;
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
        endcase
    endfunction

    // Presents a request now, and lets the next rising edge (edge N) sample it.
    // After that edge it scrambles the operand inputs.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        operandA = $urandom;
        operandB = $urandom;
    endtask

    // Counts edges until done, watching busy and HI/LO stability on the way.
    // The wait is bounded: latency stays -1 if done never arrives.
    task automatic waitForDone(output int latency, output bit busyOk, output bit holdOk);
        logic [31:0] h0;
        logic [31:0] l0;
        h0      = hi;
        l0      = lo;
        latency = -1;
        busyOk  = (busy === 1'b1);
        holdOk  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) begin
                latency = k;
                break;
            end
            if (busy !== 1'b1) busyOk = 1'b0;
            if (hi !== h0 || lo !== l0) holdOk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        op       = OpMult;
        operandA = '0;
        operandB = '0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_mult_vectors();
        int lat;
        bit bOk, hOk;
        applyStimulus(OpMult, 32'hFFFFFFFF, 32'h00000002);
        waitForDone(lat, bOk, hOk);
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 33", lat); end
        checks++; if (!bOk) begin errors++; $display("[TB] FAIL mult_busy_run: got 0 expected 1"); end
        checks++; if (!hOk) begin errors++; $display("[TB] FAIL mult_hold_run: got changed expected stable"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mult_busy_done: got %b expected 0", busy); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffffe", lo); end
        @(posedge clock);
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width: got %b expected 0", done); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL hi_hold_idle: got %h expected ffffffff", hi); end

        applyStimulus(OpMultu, 32'hFFFFFFFF, 32'h00000002);
        waitForDone(lat, bOk, hOk);
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 33", lat); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("[TB] FAIL multu_hi: got %h expected 00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL multu_lo: got %h expected fffffffe", lo); end

        applyStimulus(OpMultu, 32'h00010000, 32'h00010000);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got busy %b expected 1", busy); end
        waitForDone(lat, bOk, hOk);
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL b2b_latency: got %0d expected 33", lat); end
        checks++; if (!hOk) begin errors++; $display("[TB] FAIL b2b_hold_run: got changed expected stable"); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("[TB] FAIL b2b_hi: got %h expected 00000001", hi); end
        checks++; if (lo !== 32'h00000000) begin errors++; $display("[TB] FAIL b2b_lo: got %h expected 00000000", lo); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_random_mult();
        int lat;
        bit bOk, hOk;
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        for (int i = 0; i < 14; i++) begin
            o = 2'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (i == 0) a = 32'h80000000;
            if (i == 1) b = 32'h80000000;
            if (i == 2) a = 32'd0;
            refModel(o, a, b, eh, el);
            applyStimulus(o, a, b);
            waitForDone(lat, bOk, hOk);
            checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL rnd_mult_latency[%0d]: got %0d expected 33", i, lat); end
            checks++; if (hi !== eh) begin errors++; $display("[TB] FAIL rnd_mult_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, eh); end
            checks++; if (lo !== el) begin errors++; $display("[TB] FAIL rnd_mult_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, el); end
        end
        @(posedge clock);
        #1;
    endtask

`ifdef MULTDIV_DIVIDE_EN
    task automatic test_divide();
        int lat;
        bit bOk, hOk;
        logic [1:0]  o;
        logic [31:0] a, b, eh, el;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(2, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            case (i)
                0: begin o = OpDiv;  a = 32'hFFFFFFF9; b = 32'd2;        end
                1: begin o = OpDivu; a = 32'd100;      b = 32'd0;        end
                2: begin o = OpDiv;  a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: begin o = OpDiv;  a = 32'hFFFFFF00; b = 32'd0;        end
                default: ;
            endcase
            refModel(o, a, b, eh, el);
            applyStimulus(o, a, b);
            waitForDone(lat, bOk, hOk);
            checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL div_latency[%0d]: got %0d expected 33", i, lat); end
            checks++; if (!hOk) begin errors++; $display("[TB] FAIL div_hold_run[%0d]: got changed expected stable", i); end
            checks++; if (hi !== eh) begin errors++; $display("[TB] FAIL div_hi[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, hi, eh); end
            checks++; if (lo !== el) begin errors++; $display("[TB] FAIL div_lo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, lo, el); end
        end
        @(posedge clock);
        #1;
    endtask
`else
    task automatic test_divide_disabled();
        logic [31:0] h0, l0;
        bit busySeen, doneSeen, changed;
        for (int n = 0; n < 2; n++) begin
            h0       = hi;
            l0       = lo;
            busySeen = 1'b0;
            doneSeen = 1'b0;
            changed  = 1'b0;
            applyStimulus((n == 0) ? OpDiv : OpDivu, $urandom, $urandom | 32'd1);
            if (busy !== 1'b0) busySeen = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clock);
                #1;
                if (busy !== 1'b0) busySeen = 1'b1;
                if (done !== 1'b0) doneSeen = 1'b1;
                if (hi !== h0 || lo !== l0) changed = 1'b1;
            end
            checks++; if (busySeen) begin errors++; $display("[TB] FAIL nodiv_busy[%0d]: got 1 expected 0", n); end
            checks++; if (doneSeen) begin errors++; $display("[TB] FAIL nodiv_done[%0d]: got 1 expected 0", n); end
            checks++; if (changed) begin errors++; $display("[TB] FAIL nodiv_hilo[%0d]: got %h_%h expected %h_%h", n, hi, lo, h0, l0); end
        end
    endtask
`endif

    task automatic test_busy_ignore();
        int lat;
        bit bOk, hOk;
        applyStimulus(OpMultu, 32'd3, 32'd5);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        op       = OpMult;
        operandA = 32'd7;
        operandB = 32'd9;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ignore_busy: got %b expected 1", busy); end
        waitForDone(lat, bOk, hOk);
        checks++; if (lat !== 28) begin errors++; $display("[TB] FAIL ignore_latency: got %0d expected 28", lat); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL ignore_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd15) begin errors++; $display("[TB] FAIL ignore_lo: got %h expected 0000000f", lo); end
        @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_no_queue: got busy %b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat;
        bit bOk, hOk, sawDone, nonZero;
        logic [31:0] eh, el;
        applyStimulus(OpMultu, 32'h12345678, 32'h9ABCDEF1);
        repeat (10) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL abort_hi: got %h expected 00000000", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL abort_lo: got %h expected 00000000", lo); end
        #2;
        reset   = 1'b0;
        sawDone = 1'b0;
        nonZero = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
            if (hi !== 32'd0 || lo !== 32'd0) nonZero = 1'b1;
        end
        checks++; if (sawDone) begin errors++; $display("[TB] FAIL abort_activity: got done/busy activity expected none"); end
        checks++; if (nonZero) begin errors++; $display("[TB] FAIL abort_result_leak: got %h_%h expected 0_0", hi, lo); end

        refModel(OpMult, 32'hFFFF0001, 32'h00007FFF, eh, el);
        applyStimulus(OpMult, 32'hFFFF0001, 32'h00007FFF);
        waitForDone(lat, bOk, hOk);
        checks++; if (lat !== 33) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 33", lat); end
        checks++; if (hi !== eh) begin errors++; $display("[TB] FAIL post_reset_hi: got %h expected %h", hi, eh); end
        checks++; if (lo !== el) begin errors++; $display("[TB] FAIL post_reset_lo: got %h expected %h", lo, el); end
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_mult_vectors();
        test_random_mult();
`ifdef MULTDIV_DIVIDE_EN
        test_divide();
`else
        test_divide_disabled();
`endif
        test_busy_ignore();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, operand/result width; only 32 is supported and verified.
REQ-002 clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled on a rising edge.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 operandA  input  32  multiplicand or dividend, driven from register file port readRegA.
REQ-007 operandB  input  32  multiplier or divisor, driven from register file port readRegB.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when hi/lo take a new result.
REQ-010 hi  output  32  MIPS HI register: product upper word or remainder.
REQ-011 lo  output  32  MIPS LO register: product lower word or quotient.

Function
REQ-012 The state machine SHALL have three states: IDLE, RUN and FINISH.
REQ-013 IDLE or FINISH with start=1: latch op, operandA and operandB, clear the iteration counter, go to RUN.
REQ-014 IDLE with start=0: stay in IDLE.
REQ-015 FINISH with start=0: go to IDLE.
REQ-016 RUN: perform one radix-2 iteration per cycle (shift-add for multiply, restoring for divide) for exactly 32 cycles.
REQ-017 RUN after iteration 32: go to FINISH.
REQ-018 Latency: with start sampled at edge N, busy SHALL be 1 after edges N..N+32.
REQ-019 At edge N+33, hi/lo SHALL update, done SHALL be 1 for exactly one cycle, and busy SHALL be 0.
REQ-020 Operands are sampled only at the accepting edge; later changes on operandA/operandB SHALL NOT affect the result.
REQ-021 start while busy=1 SHALL be ignored, with no queueing.
REQ-022 start during the done cycle SHALL be accepted, giving back-to-back operations every 33 cycles.
REQ-023 hi/lo SHALL hold their value from one result update to the next and SHALL NOT change during RUN.
REQ-024 MULT/DIV are signed: the unit SHALL convert operands to magnitudes when started and apply the sign at FINISH.
REQ-025 MULTU/DIVU are unsigned.
REQ-026 Multiply: {hi,lo} SHALL equal the full 64-bit product.
REQ-027 Divide: lo SHALL be the quotient truncated toward zero, and hi the remainder with the sign of the dividend.
REQ-028 Divide by zero (any divide op): hi SHALL equal operandA, lo SHALL be 32'hFFFFFFFF, and latency SHALL be unchanged.
REQ-029 Signed overflow (32'h80000000 / 32'hFFFFFFFF): lo SHALL be 32'h80000000 and hi SHALL be 32'h00000000.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, without waiting for a clock edge.
REQ-031 reset asserted during RUN SHALL abort the operation; the discarded result SHALL never appear on hi/lo.
REQ-032 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-033 Macro MULTDIV_DIVIDE_EN defined: the divide datapath is compiled in and DIV/DIVU behave per REQ-027..029.
REQ-034 Macro MULTDIV_DIVIDE_EN undefined: the divide datapath is compiled out, and start with op[1]=1 SHALL be ignored (busy stays 0, no done, hi/lo unchanged).
REQ-035 Multiply behaviour SHALL be identical with and without MULTDIV_DIVIDE_EN.

Verification
REQ-036 MULT, A=32'hFFFFFFFF, B=32'h00000002 -> done at edge N+33; hi=32'hFFFFFFFF, lo=32'hFFFFFFFE.
REQ-037 MULTU, same operands -> hi=32'h00000001, lo=32'hFFFFFFFE; then back-to-back MULTU 32'h00010000*32'h00010000 started in the done cycle -> hi=32'h00000001, lo=0 after 33 more cycles.
REQ-038 DIV, A=32'hFFFFFFF9 (-7), B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-039 DIVU, A=100, B=0 -> hi=32'h00000064, lo=32'hFFFFFFFF.
REQ-040 DIV, A=32'h80000000, B=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-041 Start MULTU 3*5, change operands and pulse start at edge N+5 -> ignored, lo=15; separately, assert reset at edge N+10 -> busy=0 and hi=lo=0 immediately, with no done pulse.
REQ-042 Build without MULTDIV_DIVIDE_EN and issue DIV -> busy stays 0 and hi/lo keep the prior values for 40 cycles.
